sha256_msg_schedule: RTL and testbench
======================================

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

Interface
REQ-001 SHALL have parameter N, default 32, the word width; only 32 is supported.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start_i, input, 1, a request to load a new 512-bit block.
REQ-005 SHALL have port block_i, input, 16 x N (index 0..15), message words M0..M15; index 0 is the first word.
REQ-006 SHALL have port ready_i, input, 1, downstream round stage accepts the current beat.
REQ-007 SHALL have port busy_o, output, 1, high while a schedule is in progress.
REQ-008 SHALL have port valid_o, output, 1, w_o, k_o and round_o are meaningful.
REQ-009 SHALL have port w_o, output, N, schedule word W[t].
REQ-010 SHALL have port k_o, output, N, round constant K[t].
REQ-011 SHALL have port round_o, output, 6, round index t.
REQ-012 SHALL have port done_o, output, 1, one-cycle pulse on acceptance of beat t=63.

Function
REQ-013 SHALL implement an FSM with states IDLE and RUN; the reset state is IDLE.
REQ-014 In IDLE, start_i=1 SHALL load window[0..15] <= block_i[0..15], clear t to 0 and enter RUN at the next edge.
REQ-015 start_i while in RUN SHALL be ignored; the block in progress is unaffected.
REQ-016 In RUN, valid_o SHALL be 1 with w_o=window[0], k_o=K[t] and round_o=t, all registered with no combinational path from ready_i to these outputs.
REQ-017 A beat SHALL be accepted when valid_o=1 and ready_i=1; on acceptance the window shifts by one (window[i] <= window[i+1]), window[15] <= new word, and t increments.
REQ-018 The new word SHALL be sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^32 with carries discarded.
REQ-019 sigma0(x) SHALL be ROTR7 ^ ROTR18 ^ SHR3, and sigma1(x) SHALL be ROTR17 ^ ROTR19 ^ SHR10.
REQ-020 With ready_i=0, the window, t and all outputs SHALL hold unchanged (stall), for any duration.
REQ-021 Acceptance at t=63 SHALL assert done_o in that same cycle and return the FSM to IDLE at the next edge, with valid_o=0 afterwards.
REQ-022 With ready_i held at 1, the first valid beat SHALL appear one cycle after start_i is sampled, and the beats SHALL span exactly 64 consecutive cycles.
REQ-023 start_i=1 in the first IDLE cycle after done_o SHALL begin a new block (back-to-back, one idle cycle between schedules).
REQ-024 busy_o SHALL equal (state == RUN).
REQ-025 t SHALL never wrap past 63 within a block.

Reset
REQ-026 rst_i=0 SHALL, asynchronously and at any time including mid-RUN, force state=IDLE, t=0, busy_o=0, valid_o=0, done_o=0, w_o=0, k_o=0, round_o=0 and window=0.
REQ-027 The first start_i after reset release SHALL behave exactly as in REQ-014.

Structure
REQ-028 A shared package sha256_pkg SHALL hold the 64-entry K constant array (K[0]=0x428A2F98 .. K[63]=0xC67178F2), the word width constant and the sigma0/sigma1 functions; it is reused by the round stage.
REQ-029 Modulo additions SHALL reuse the team's existing adder or plain combinational 32-bit adds; no other sub-module is required.
REQ-030 The window SHALL be a 16-entry register array; no RAM SHALL be inferred.

Verification
REQ-031 SHALL cover "abc" padded block (M0=0x61626380, M1..M14=0, M15=0x00000018) with ready_i=1: expect W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, and W18..W63 matching a reference model.
REQ-032 SHALL cover K sequencing: k_o=0x428A2F98 at round 0, 0x71374491 at round 1, 0xC67178F2 at round 63, and exactly 64 valid beats.
REQ-033 SHALL cover a stall: ready_i=0 for 5 cycles at t=20, expecting w_o, k_o and round_o held for those cycles, then the sequence to resume identical to the unstalled run.
REQ-034 SHALL cover start_i pulsed at t=30 with a different block, expecting no effect and the output identical to REQ-031.
REQ-035 SHALL cover rst_i=0 asserted at t=40, expecting all outputs 0 immediately; after release, a new start_i yields the full correct sequence from t=0.
REQ-036 SHALL cover two blocks back-to-back, expecting one idle cycle between them, done_o exactly once per block, and W0 of block 2 equal to M0 of block 2.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 definitions used by the message schedule and the
// round stage. It holds the word width, the 64 round constants K[0..63], the
// small sigma functions and the schedule FSM state type.
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotate right by a constant amount; n is always a literal at the call site.
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// sha256_msg_schedule_if: block-load / beat handshake between a block source,
// the message schedule and the downstream round stage.
//   start_i  - request to load a new 512-bit block (block_i)
//   block_i  - message words M0..M15, index 0 first
//   ready_i  - downstream accepts the current beat
//   busy_o   - schedule in progress
//   valid_o  - w_o / k_o / round_o are meaningful
//   w_o      - schedule word W[t]
//   k_o      - round constant K[t]
//   round_o  - round index t
//   done_o   - pulse on acceptance of beat t=63
// master drives the block and ready (source/round stage side), slave is the
// schedule itself.
interface sha256_msg_schedule_if #(
  parameter int N = 32
);
  logic         start_i;
  logic [N-1:0] block_i [16];
  logic         ready_i;
  logic         busy_o;
  logic         valid_o;
  logic [N-1:0] w_o;
  logic [N-1:0] k_o;
  logic [5:0]   round_o;
  logic         done_o;

  modport master (
    output start_i, block_i, ready_i,
    input  busy_o, valid_o, w_o, k_o, round_o, done_o
  );

  modport slave (
    input  start_i, block_i, ready_i,
    output busy_o, valid_o, w_o, k_o, round_o, done_o
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: expands a 16-word message block into the 64 SHA-256
// schedule words W[0..63], presenting one word per accepted beat together
// with its round constant K[t] and round index t.
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-low reset
//   bus   - handshake/data bundle (slave side), see sha256_msg_schedule_if
//
// state | meaning
// IDLE  | waiting for start_i; outputs hold, valid_o=0
// RUN   | presenting W[t]/K[t]; advances on valid_o & ready_i
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int N = 32
) (
  input logic                   clk_i,
  input logic                   rst_i,
  sha256_msg_schedule_if.slave  bus
);

  sched_state_e state_q, state_d;
  logic [N-1:0] window_q [16];
  logic [N-1:0] window_d [16];
  logic [5:0]   t_q, t_d;
  logic [N-1:0] k_q, k_d;
  logic [N-1:0] new_word;
  logic         accept;
  logic         last_beat;

  assign accept    = (state_q == RUN) && bus.ready_i;
  assign last_beat = (t_q == 6'd63);

  always_comb begin
    new_word = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];

    state_d  = state_q;
    window_d = window_q;
    t_d      = t_q;
    k_d      = k_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          window_d = bus.block_i;
          t_d      = 6'd0;
          k_d      = K[0];
          state_d  = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          // On the last beat, t stays at 63 and the window is left as is;
          // the outputs simply hold while valid_o drops.
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            for (int i = 0; i < 15; i++) window_d[i] = window_q[i+1];
            window_d[15] = new_word;
            t_d          = t_q + 6'd1;
            k_d          = K[t_q + 6'd1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      t_q     <= '0;
      k_q     <= '0;
      for (int i = 0; i < 16; i++) window_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      k_q      <= k_d;
      window_q <= window_d;
    end
  end

  assign bus.busy_o  = (state_q == RUN);
  assign bus.valid_o = (state_q == RUN);
  assign bus.w_o     = window_q[0];
  assign bus.k_o     = k_q;
  assign bus.round_o = t_q;
  // done_o must coincide with the accepting cycle, so it follows ready_i.
  assign bus.done_o  = accept && last_beat;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

  typedef logic [31:0] word_t;

  typedef struct {
    int    t;
    word_t w;
    word_t k;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_schedule_if #(.N(32)) bus ();

  sha256_msg_schedule #(.N(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  word_t kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  word_t abc_blk [16];
  word_t alt_blk [16];
  word_t ref_w   [64];
  word_t alt_w   [64];
  word_t cap_w   [64];
  word_t cap_k   [64];
  vec_t  tbl     [6];

  int beats, dones, first_cyc, last_cyc;
  bit aborted;

  function automatic word_t rr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t s0(input word_t x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic model(input word_t blk [16], output word_t w [64]);
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++) w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},  {31'd0, bus.busy_o},  32'd0);
    chk({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd0);
    chk({tag, "_done"},  {31'd0, bus.done_o},  32'd0);
    chk({tag, "_w"},     bus.w_o,              32'd0);
    chk({tag, "_k"},     bus.k_o,              32'd0);
    chk({tag, "_round"}, {26'd0, bus.round_o}, 32'd0);
  endtask

  // Called at a negedge. Loads blk, then services beats with ready=1, with
  // optional stall (5 cycles at stall_t), a foreign start pulse at pulse_t,
  // or a reset assertion at rst_t (returns with rst_n low).
  task automatic run_sched(input word_t blk [16], input int stall_t, input int pulse_t, input int rst_t);
    int    cyc;
    bit    stalled;
    word_t hw, hk;
    logic [5:0] hr;
    beats = 0; dones = 0; first_cyc = -1; last_cyc = -1; aborted = 0; stalled = 0;
    bus.block_i = blk;
    bus.start_i = 1'b1;
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (!bus.valid_o) begin
        if (beats > 0) break;
      end else begin
        if (rst_t >= 0 && int'(bus.round_o) == rst_t) begin
          rst_n = 1'b0;
          #1;
          chk_zero_outputs("rst_mid");
          aborted = 1;
          break;
        end
        if (stall_t >= 0 && int'(bus.round_o) == stall_t && !stalled) begin
          stalled = 1;
          hw = bus.w_o; hk = bus.k_o; hr = bus.round_o;
          bus.ready_i = 1'b0;
          repeat (5) begin
            @(negedge clk);
            chk("stall_w", bus.w_o, hw);
            chk("stall_k", bus.k_o, hk);
            chk("stall_round", {26'd0, bus.round_o}, {26'd0, hr});
            chk("stall_valid", {31'd0, bus.valid_o}, 32'd1);
            chk("stall_done", {31'd0, bus.done_o}, 32'd0);
          end
          bus.ready_i = 1'b1;
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        chk("round_seq", {26'd0, bus.round_o}, beats);
        chk("busy_run", {31'd0, bus.busy_o}, 32'd1);
        chk("done_pulse", {31'd0, bus.done_o}, (beats == 63) ? 32'd1 : 32'd0);
        cap_w[bus.round_o] = bus.w_o;
        cap_k[bus.round_o] = bus.k_o;
        if (bus.done_o) dones++;
        beats++;
        if (pulse_t >= 0 && int'(bus.round_o) == pulse_t) begin
          bus.block_i = alt_blk;
          bus.start_i = 1'b1;
        end
      end
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    if (!aborted && cyc >= 200) chk("sched_timeout", cyc, 32'd0);
  endtask

  task automatic compare_all(input string tag, input word_t exp_w [64]);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("%s_w[%0d]", tag, i), cap_w[i], exp_w[i]);
      chk($sformatf("%s_k[%0d]", tag, i), cap_k[i], kt[i]);
    end
  endtask

  task automatic chk_block_shape(input string tag);
    chk({tag, "_beats"}, beats, 32'd64);
    chk({tag, "_dones"}, dones, 32'd1);
    chk({tag, "_first_latency"}, first_cyc, 32'd0);
    chk({tag, "_span"}, last_cyc - first_cyc + 1, 32'd64);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 16; i++) bus.block_i[i] = '0;

    for (int i = 0; i < 16; i++) abc_blk[i] = 32'd0;
    abc_blk[0]  = 32'h61626380;
    abc_blk[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) alt_blk[i] = (32'h01010101 * i) ^ 32'hdeadbeef;
    model(abc_blk, ref_w);
    model(alt_blk, alt_w);

    tbl[0] = '{0,  32'h61626380, 32'h428a2f98};
    tbl[1] = '{1,  32'h00000000, 32'h71374491};
    tbl[2] = '{15, 32'h00000018, 32'hc19bf174};
    tbl[3] = '{16, 32'h61626380, 32'he49b69c1};
    tbl[4] = '{17, 32'h000f0000, 32'hefbe4786};
    tbl[5] = '{63, ref_w[63],    32'hc67178f2};

    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", {31'd0, bus.valid_o}, 32'd0);

    // plain "abc" block
    run_sched(abc_blk, -1, -1, -1);
    chk_block_shape("abc");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("tbl_w[%0d]", tbl[i].t), cap_w[tbl[i].t], tbl[i].w);
      chk($sformatf("tbl_k[%0d]", tbl[i].t), cap_k[tbl[i].t], tbl[i].k);
    end
    compare_all("abc", ref_w);

    // back-to-back: start in the first idle cycle after done
    chk("b2b_idle_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("b2b_idle_busy", {31'd0, bus.busy_o}, 32'd0);
    run_sched(alt_blk, -1, -1, -1);
    chk_block_shape("b2b");
    chk("b2b_w0", cap_w[0], alt_blk[0]);
    compare_all("b2b", alt_w);

    // stall at t=20
    run_sched(abc_blk, 20, -1, -1);
    chk("stall_beats", beats, 32'd64);
    chk("stall_dones", dones, 32'd1);
    compare_all("stall", ref_w);

    // start pulsed mid-run with another block
    run_sched(abc_blk, -1, 30, -1);
    chk_block_shape("pulse");
    compare_all("pulse", ref_w);

    // reset at t=40, then a fresh block
    run_sched(abc_blk, -1, -1, 40);
    chk("rst_aborted", {31'd0, aborted}, 32'd1);
    @(negedge clk);
    chk_zero_outputs("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    run_sched(abc_blk, -1, -1, -1);
    chk_block_shape("post_rst");
    compare_all("post_rst", ref_w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
